fifo36_to_ll8: RTL and testbench

- Downstream stage of the 36-bit short FIFO: consumes 36-bit framed words (datain/src_rdy_i/dst_rdy_o) and emits an 8-bit LocalLink-style byte stream with SOF/EOF toward the GEMAC TX path.
- Word format: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy (valid bytes in the EOF word).
- One-word holding register and byte-index counter; full throughput of 4 bytes per word with no inter-word bubbles.

---
 rtl/fifo36_to_ll8_if.sv | 22 ++
 rtl/fifo36_to_ll8.sv | 98 +++++++++
 tb/tb_fifo36_to_ll8.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo36_to_ll8_if.sv
// Framed 36-bit word input and 8-bit LocalLink byte output bundle.
`timescale 1ns/1ps
interface fifo36_to_ll8_if;
    logic [35:0] datain;
    logic        src_rdy_i;
    logic        dst_rdy_o;
    logic [7:0]  dataout;
    logic        sof_o;
    logic        eof_o;
    logic        src_rdy_o;
    logic        dst_rdy_i;

    modport slave (
        input  datain, src_rdy_i, dst_rdy_i,
        output dst_rdy_o, dataout, sof_o, eof_o, src_rdy_o
    );

    modport master (
        output datain, src_rdy_i, dst_rdy_i,
        input  dst_rdy_o, dataout, sof_o, eof_o, src_rdy_o
    );
endinterface

// File: rtl/fifo36_to_ll8.sv
// Unpacks 36-bit framed FIFO words into an 8-bit SOF/EOF byte stream.
// Define FIFO36_TO_LL8_FRAME_CHECK_EN to drop non-SOF words outside a packet.
`timescale 1ns/1ps
module fifo36_to_ll8 #(
    parameter bit LE = 1'b0
) (
    input logic            clock,
    input logic            reset,
    input logic            clear,
    fifo36_to_ll8_if.slave bus
);

    logic        valid_q, valid_d;
    logic [1:0]  idx_q, idx_d;
    logic [35:0] word_q, word_d;
    logic        in_pkt_q, in_pkt_d;

    logic        flush;
    logic [1:0]  last_idx;
    logic        last_byte;
    logic        xfer;
    logic        accept;
    logic        drop;
    logic        eof_byte;
    logic        live_pkt;
    logic [1:0]  lane;
    logic [7:0]  byte_sel;

    assign flush = reset | clear;

    // Occupancy 0 in an EOF word means all four bytes are valid.
    always_comb begin
        last_idx = 2'd3;
        if (word_q[33] && (word_q[35:34] != 2'd0))
            last_idx = word_q[35:34] - 2'd1;
    end

    assign last_byte = (idx_q == last_idx);
    assign xfer      = valid_q & bus.dst_rdy_i;
    assign eof_byte  = valid_q & word_q[33] & last_byte;

    assign bus.dst_rdy_o = ~flush &
                           (~valid_q | (last_byte & bus.dst_rdy_i));
    assign accept = bus.src_rdy_i & bus.dst_rdy_o;

    // Packet state as seen by a word arriving alongside the eof byte.
    assign live_pkt = in_pkt_q & ~(xfer & eof_byte);

`ifdef FIFO36_TO_LL8_FRAME_CHECK_EN
    assign drop = ~live_pkt & ~bus.datain[32];
`else
    assign drop = 1'b0;
`endif

    assign lane     = LE ? idx_q : ~idx_q;
    assign byte_sel = word_q[{lane, 3'b000} +: 8];

    assign bus.src_rdy_o = valid_q;
    assign bus.dataout   = valid_q ? byte_sel : 8'h00;
    assign bus.sof_o     = valid_q & word_q[32] & (idx_q == 2'd0);
    assign bus.eof_o     = eof_byte;

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        word_d   = word_q;
        in_pkt_d = live_pkt;
        if (xfer) begin
            if (last_byte) begin
                valid_d = 1'b0;
                idx_d   = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
        if (accept && bus.datain[32])
            in_pkt_d = 1'b1;
        if (accept && !drop) begin
            valid_d = 1'b1;
            idx_d   = 2'd0;
            word_d  = bus.datain;
        end
    end

    always_ff @(posedge clock) begin
        word_q <= word_d;
        if (flush) begin
            valid_q  <= 1'b0;
            idx_q    <= 2'd0;
            in_pkt_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            in_pkt_q <= in_pkt_d;
        end
    end

endmodule

// File: tb/tb_fifo36_to_ll8.sv
// Bench for fifo36_to_ll8: directed vector table plus random traffic
// compared against a byte-queue reference model.
`timescale 1ns/1ps
module tb_fifo36_to_ll8;

    logic clock = 1'b0;
    logic reset;
    logic clear;

    fifo36_to_ll8_if bus();

    fifo36_to_ll8 #(.LE(1'b0)) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp_v, $time);
        end
    endtask

    // Reference model: bytes still owed from the word being unpacked.
    typedef struct {
        logic [7:0] d;
        bit         s;
        bit         e;
    } mbyte_t;

    mbyte_t mq[$];
    bit     m_inpkt = 0;
    bit     mon     = 0;

    function automatic bit exp_dst();
        return !(reset || clear) &&
               (mq.size() == 0 ||
                (mq.size() == 1 && bus.dst_rdy_i));
    endfunction

    task automatic push_word(input logic [35:0] w);
        bit sof;
        bit eof;
        int n;
        sof = w[32];
        eof = w[33];
        n   = (eof && w[35:34] != 2'd0) ? int'(w[35:34]) : 4;
`ifdef FIFO36_TO_LL8_FRAME_CHECK_EN
        if (!m_inpkt && !sof) return;
`endif
        if (sof) m_inpkt = 1;
        for (int i = 0; i < n; i++) begin
            mbyte_t b;
            b.d = w[31 - 8*i -: 8];
            b.s = sof && (i == 0);
            b.e = eof && (i == n - 1);
            mq.push_back(b);
        end
    endtask

    always @(posedge clock) begin
        bit acc;
        bit pop;
        cyc++;
        acc = bus.src_rdy_i && exp_dst();
        pop = (mq.size() != 0) && bus.dst_rdy_i;
        if (reset || clear) begin
            mq.delete();
            m_inpkt = 0;
            if (reset) mon = 1;
        end else begin
            if (pop) begin
                if (mq[0].e) m_inpkt = 0;
                void'(mq.pop_front());
            end
            if (acc) push_word(bus.datain);
        end
    end

    always @(negedge clock) begin
        if (mon) begin
            if (mq.size() != 0) begin
                chk("m_src_rdy", bus.src_rdy_o, 1'b1);
                chk("m_data", bus.dataout, mq[0].d);
                chk("m_sof", bus.sof_o, mq[0].s);
                chk("m_eof", bus.eof_o, mq[0].e);
            end else begin
                chk("m_src_rdy", bus.src_rdy_o, 1'b0);
                chk("m_data", bus.dataout, 8'h00);
                chk("m_sof", bus.sof_o, 1'b0);
                chk("m_eof", bus.eof_o, 1'b0);
            end
            chk("m_dst_rdy", bus.dst_rdy_o, exp_dst());
        end
    end

    // Capture of completed byte transfers for the directed tests.
    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        int         c;
    } rec_t;

    rec_t       lg[$];
    logic [7:0] eq[$];

    always @(negedge clock) begin
        if (!reset && !clear && bus.src_rdy_o === 1'b1 &&
            bus.dst_rdy_i === 1'b1) begin
            rec_t r;
            r.d = bus.dataout;
            r.s = bus.sof_o;
            r.e = bus.eof_o;
            r.c = cyc;
            lg.push_back(r);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        bus.src_rdy_i = 1'b0;
        bus.dst_rdy_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_dst_rdy", bus.dst_rdy_o, 1'b0);
        chk("rst_src_rdy", bus.src_rdy_o, 1'b0);
        chk("rst_data", bus.dataout, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle_dst_rdy", bus.dst_rdy_o, 1'b1);
        chk("idle_sof", bus.sof_o, 1'b0);
        chk("idle_eof", bus.eof_o, 1'b0);
        tick();
    endtask

    task automatic send(input logic [35:0] w);
        bit ok;
        ok = 0;
        bus.datain    = w;
        bus.src_rdy_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (bus.dst_rdy_o === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%0h", w);
        end
        @(posedge clock);
        #1;
        bus.src_rdy_i = 1'b0;
    endtask

    task automatic check_log(input string nm, input logic [15:0] sm,
                             input logic [15:0] em, input bit gapless);
        chk({nm, "_len"}, lg.size(), eq.size());
        for (int i = 0; i < eq.size() && i < lg.size(); i++) begin
            chk({nm, "_byte"}, lg[i].d, eq[i]);
            chk({nm, "_sof"}, lg[i].s, sm[i]);
            chk({nm, "_eof"}, lg[i].e, em[i]);
            if (gapless)
                chk({nm, "_gap"}, lg[i].c - lg[0].c, i);
        end
    endtask

    typedef struct {
        logic [35:0] w;
        int          n;
        logic [31:0] b;
        bit          s;
        bit          e;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{36'h3_DEADBEEF, 4, 32'hDEADBEEF, 1'b1, 1'b1};
        tbl[1] = '{36'h7_AA000000, 1, 32'hAA000000, 1'b1, 1'b1};
        tbl[2] = '{36'hF_CAFEF00D, 3, 32'hCAFEF000, 1'b1, 1'b1};
`ifdef FIFO36_TO_LL8_FRAME_CHECK_EN
        tbl[3] = '{36'h0_11223344, 0, 32'h11223344, 1'b0, 1'b0};
`else
        tbl[3] = '{36'h0_11223344, 4, 32'h11223344, 1'b0, 1'b0};
`endif
        reset         = 1'b1;
        clear         = 1'b0;
        bus.datain    = '0;
        bus.src_rdy_i = 1'b0;
        bus.dst_rdy_i = 1'b1;

        foreach (tbl[t]) begin
            do_reset();
            lg.delete();
            send(tbl[t].w);
            repeat (8) tick();
            chk("tbl_len", lg.size(), tbl[t].n);
            for (int i = 0; i < tbl[t].n && i < lg.size(); i++) begin
                chk("tbl_byte", lg[i].d, tbl[t].b[31 - 8*i -: 8]);
                chk("tbl_sof", lg[i].s, tbl[t].s && i == 0);
                chk("tbl_eof", lg[i].e, tbl[t].e && i == tbl[t].n - 1);
            end
        end

        // Two-word packet back to back; EOF occupancy 2 truncates.
        do_reset();
        lg.delete();
        send(36'h1_01020304);
        send(36'hA_05060708);
        repeat (8) tick();
        eq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        check_log("b2b", 16'h0001, 16'h0020, 1'b1);

        // Single-byte packet followed by a full word with no bubble.
        lg.delete();
        send(36'h7_AA000000);
        send(36'h3_DEADBEEF);
        repeat (8) tick();
        eq = {8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_log("one", 16'h0003, 16'h0011, 1'b1);

        // Downstream backpressure 1,0,0 repeating.
        lg.delete();
        fork
            begin
                send(36'h1_01020304);
                send(36'hA_05060708);
                send(36'h3_DEADBEEF);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    bus.dst_rdy_i = (i % 3 == 0);
                    tick();
                end
            end
        join
        bus.dst_rdy_i = 1'b1;
        repeat (8) tick();
        eq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_log("bp", 16'h0041, 16'h0220, 1'b0);

        // Clear after two bytes of a four-byte word.
        do_reset();
        lg.delete();
        send(36'h3_DEADBEEF);
        tick();
        tick();
        clear = 1'b1;
        @(negedge clock);
        chk("clr_dst_rdy", bus.dst_rdy_o, 1'b0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        chk("clr_src_rdy", bus.src_rdy_o, 1'b0);
        chk("clr_dst_after", bus.dst_rdy_o, 1'b1);
        tick();
        eq = {8'hDE, 8'hAD};
        check_log("pre_clr", 16'h0001, 16'h0000, 1'b1);
        lg.delete();
        send(36'h3_01020304);
        repeat (8) tick();
        eq = {8'h01, 8'h02, 8'h03, 8'h04};
        check_log("post_clr", 16'h0001, 16'h0008, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bus.src_rdy_i = ($urandom_range(3) != 0);
            bus.datain    = {4'($urandom), 32'($urandom)};
            bus.dst_rdy_i = ($urandom_range(3) != 0);
            clear         = ($urandom_range(99) == 0);
            tick();
        end
        clear         = 1'b0;
        bus.src_rdy_i = 1'b0;
        bus.dst_rdy_i = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
